sseg_display_driver: RTL and testbench
======================================

SSEG_DISPLAY_DRIVER -- requirements
Module: sseg_display_driver

Interface
REQ-001 Parameter: BLANK_LEADING, 1, when 1 suppress leading decimal zeros; when 0 show all five digits.
REQ-002 CLOCK_50  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  one-cycle request to display value.
REQ-005 value  input  16  two's-complement stack-top value.
REQ-006 hex_mode  input  1  sampled with load; 1 = raw hexadecimal display, 0 = signed decimal.
REQ-007 busy  output  1  high while a request is in progress.
REQ-008 done  output  1  one-cycle pulse when HEX outputs take the new value.
REQ-009 HEX0..HEX5  output  7 each  active-low segment codes {g,f,e,d,c,b,a}; HEX0 is the least significant digit.

Function
REQ-010 Single clock, synchronous active-high reset, as fixed above.
REQ-011 Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-012 Blank code is 1111111; minus code is 0111111.
REQ-013 FSM states: IDLE, CONV, SHOW; reset enters IDLE.
REQ-014 IDLE with load=1: capture sign=value[15], magnitude=|value| as 16-bit unsigned, and hex_mode.
REQ-015 On the load edge, go to CONV when hex_mode=0, or to SHOW when hex_mode=1.
REQ-016 Magnitude rule: -32768 gives magnitude 32768; no overflow is possible.
REQ-017 CONV: shift-and-add-3 binary-to-BCD, one bit per cycle, exactly 16 cycles, into five 4-bit BCD digits; then go to SHOW.
REQ-018 SHOW: lasts one cycle; registers all six HEX outputs; asserts done for the following cycle; returns to IDLE.
REQ-019 Decimal latency: done high in the cycle after the 18th rising edge counted from the edge that samples load; HEX changes on that same 18th edge.
REQ-020 Hex-mode latency: done and HEX update 2 edges after the load edge.
REQ-021 busy is high from the edge after load until the edge on which done rises; busy and done are never high together.
REQ-022 load while busy=1 is ignored: no queueing, and the captured operands are unchanged.
REQ-023 load is accepted in the same cycle done is high.
REQ-024 HEX outputs hold the previous display throughout CONV; no intermediate codes appear.
REQ-025 Decimal display: BCD digits 0..4 on HEX0..HEX4.
REQ-026 Leading blanking (BLANK_LEADING=1): a digit is blanked if it and all more-significant digits are zero; HEX0 is never blanked.
REQ-027 Sign display: HEX5 shows minus if sign=1, otherwise blank; HEX5 never shows a digit.
REQ-028 Hex-mode display: value[3:0]..value[15:12] on HEX0..HEX3 as raw two's-complement nibbles, no blanking; HEX4 and HEX5 blank.
REQ-029 Zero displays as HEX0=1000000 with HEX1..HEX5 blank when BLANK_LEADING=1.

Reset
REQ-030 Reset values: state IDLE, busy=0, done=0, HEX0=1000000, HEX1..HEX5=1111111, BCD and shift registers cleared.
REQ-031 Reset asserted mid-CONV or mid-SHOW aborts the request: no done pulse, and the reset values appear on the next edge.
REQ-032 Reset has priority over load in the same cycle.

Verification
REQ-033 load value=5, hex_mode=0 -> after 18 edges, done=1 for one cycle; HEX0=0010010; HEX1..HEX5=1111111.
REQ-034 load value=73, then load value=-5 sent while busy -> value -5 ignored; HEX1=1111000, HEX0=0110000, others blank; exactly one done pulse.
REQ-035 load value=-32768 -> HEX5=0111111, HEX4..HEX0 = 3,2,7,6,8 (0110000, 0100100, 1111000, 0000010, 0000000).
REQ-036 load value=16'hFFFB, hex_mode=1 -> after 2 edges, HEX3..HEX0 = F,F,F,b (0001110 x3, 0000011); HEX4, HEX5 blank.
REQ-037 load value=5 (product of -1 and -5), reset pulsed at cycle 8 -> no done; HEX returns to reset values; a new load of 13 (sum of 5 and 8) then displays HEX1=1111001, HEX0=0110000.
REQ-038 BLANK_LEADING=0, load value=0 -> HEX0..HEX4=1000000, HEX5 blank.

Source files
------------

// File: rtl/sseg_display_driver_if.sv
// Bundles the request/response handshake and segment outputs of the
// seven-segment display driver.
//
// Handshake: the master raises load for one cycle with value/hex_mode valid
// alongside it. The request is accepted only when busy is low; a load seen
// while busy is high is dropped. busy rises on the edge after acceptance and
// falls on the edge where done rises. done is a one-cycle pulse marking the
// cycle in which HEX0..HEX5 first carry the new display. A new load may be
// presented in the same cycle that done is high.
interface sseg_display_driver_if;
    logic        load;
    logic [15:0] value;
    logic        hex_mode;
    logic        busy;
    logic        done;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [6:0]  HEX4;
    logic [6:0]  HEX5;

    modport master (
        output load, value, hex_mode,
        input  busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  load, value, hex_mode,
        output busy, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/sseg_display_driver.sv
// Seven-segment display driver: shows a 16-bit two's-complement value either
// as signed decimal (serial shift-and-add-3 conversion, 16 cycles) or as four
// raw hexadecimal nibbles. Segment codes are active-low {g,f,e,d,c,b,a}.
module sseg_display_driver #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    sseg_display_driver_if.slave        bus,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    state_t      state;
    logic        sign_q;
    logic        hex_sel_q;
    logic [15:0] shift_q;   // magnitude being shifted out (decimal) or raw value (hex)
    logic [19:0] bcd_q;     // five BCD digits, digit 0 in bits [3:0]
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [6:0]  hex_q [6];

    logic [19:0] bcd_adj;
    logic [6:0]  hex_nxt [6];
    logic [15:0] magnitude;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0011000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Absolute value; 16'h8000 negates to itself, which read unsigned is 32768.
    assign magnitude = bus.value[15] ? (~bus.value + 16'd1) : bus.value;

    // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment codes for the display about to be shown, with leading blanking.
    always_comb begin
        logic leading;
        leading = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hex_nxt[i] = SEG_BLANK;
        end
        if (hex_sel_q) begin
            for (int i = 0; i < 4; i++) begin
                hex_nxt[i] = seg7(shift_q[4*i +: 4]);
            end
        end else begin
            for (int i = 4; i >= 1; i--) begin
                if (BLANK_LEADING && leading && (bcd_q[4*i +: 4] == 4'd0)) begin
                    hex_nxt[i] = SEG_BLANK;
                end else begin
                    leading    = 1'b0;
                    hex_nxt[i] = seg7(bcd_q[4*i +: 4]);
                end
            end
            hex_nxt[0] = seg7(bcd_q[3:0]);
            hex_nxt[5] = sign_q ? SEG_MINUS : SEG_BLANK;
        end
    end

    // Control FSM: capture on load, serial conversion, then a one-cycle show.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            hex_sel_q <= 1'b0;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hex_q[0]  <= SEG_ZERO;
            for (int i = 1; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        sign_q    <= bus.value[15];
                        hex_sel_q <= bus.hex_mode;
                        shift_q   <= bus.hex_mode ? bus.value : magnitude;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state     <= bus.hex_mode ? SHOW : CONV;
                    end
                end
                CONV: begin
                    bcd_q   <= {bcd_adj[18:0], shift_q[15]};
                    shift_q <= {shift_q[14:0], 1'b0};
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    for (int i = 0; i < 6; i++) begin
                        hex_q[i] <= hex_nxt[i];
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.HEX0  = hex_q[0];
    assign bus.HEX1  = hex_q[1];
    assign bus.HEX2  = hex_q[2];
    assign bus.HEX3  = hex_q[3];
    assign bus.HEX4  = hex_q[4];
    assign bus.HEX5  = hex_q[5];
    assign dbg_state = state;

endmodule

// File: tb/tb_sseg_display_driver.sv
// Directed bench for the seven-segment display driver: one instance with
// leading blanking, one without.
module tb_sseg_display_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           SA = 7'b0001000, SLB = 7'b0000011, SF = 7'b0001110,
                           SB = 7'b1111111, SM = 7'b0111111;

    localparam logic [41:0] RESET_HEX = {SB, SB, SB, SB, SB, S0};

    logic       CLOCK_50;
    logic       reset;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state2;
    int         n_vec;
    int         n_err;

    sseg_display_driver_if bus ();
    sseg_display_driver_if bus2 ();

    sseg_display_driver #(.BLANK_LEADING(1'b1)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    sseg_display_driver #(.BLANK_LEADING(1'b0)) dut2 (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .bus       (bus2.slave),
        .dbg_state (dbg_state2)
    );

    wire [41:0] hex1 = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    wire [41:0] hex2 = {bus2.HEX5, bus2.HEX4, bus2.HEX3, bus2.HEX2, bus2.HEX1, bus2.HEX0};

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [41:0] got, input logic [41:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Issue a load on dut and follow it for n_edges edges (load edge = 1).
    // If inj > 0, a second load of -5 is pushed during edge inj while busy.
    // Returns with done high, i.e. in the cycle after the final edge.
    task automatic run_load(input string tag, input logic [15:0] v, input logic hm,
                            input int n_edges, input int inj, input logic [41:0] exp);
        logic [41:0] prev;
        int          early_done;
        int          hex_moves;
        int          both_high;
        prev       = hex1;
        early_done = 0;
        hex_moves  = 0;
        both_high  = 0;
        bus.load     = 1'b1;
        bus.value    = v;
        bus.hex_mode = hm;
        step();
        bus.load = 1'b0;
        check_eq({tag, " busy after load"}, 42'(bus.busy), 42'(1));
        check_eq({tag, " done after load"}, 42'(bus.done), 42'(0));
        for (int i = 2; i < n_edges; i++) begin
            if (i == inj) begin
                bus.load     = 1'b1;
                bus.value    = 16'hFFFB;
                bus.hex_mode = 1'b0;
            end
            step();
            bus.load = 1'b0;
            if (bus.done) early_done++;
            if (hex1 !== prev) hex_moves++;
            if (bus.busy && bus.done) both_high++;
        end
        if (n_edges > 2) begin
            check_eq({tag, " no early done"}, 42'(early_done), 42'(0));
            check_eq({tag, " hex held"}, 42'(hex_moves), 42'(0));
            check_eq({tag, " busy&done"}, 42'(both_high), 42'(0));
        end
        step();
        check_eq({tag, " done"}, 42'(bus.done), 42'(1));
        check_eq({tag, " busy cleared"}, 42'(bus.busy), 42'(0));
        check_eq({tag, " hex"}, hex1, exp);
    endtask

    initial begin
        int dcount;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.load = 1'b0;  bus.value = '0;  bus.hex_mode = 1'b0;
        bus2.load = 1'b0; bus2.value = '0; bus2.hex_mode = 1'b0;
        step();
        step();
        reset = 1'b0;

        check_eq("reset hex", hex1, RESET_HEX);
        check_eq("reset hex2", hex2, RESET_HEX);
        check_eq("reset busy", 42'(bus.busy), 42'(0));
        check_eq("reset done", 42'(bus.done), 42'(0));
        check_eq("reset state", 42'(dbg_state), 42'(0));

        // reset wins over load in the same cycle
        reset = 1'b1; bus.load = 1'b1; bus.value = 16'd7;
        step();
        reset = 1'b0; bus.load = 1'b0;
        check_eq("rst prio busy", 42'(bus.busy), 42'(0));
        check_eq("rst prio hex", hex1, RESET_HEX);
        step();
        check_eq("rst prio no done", 42'(bus.done), 42'(0));

        run_load("dec5", 16'd5, 1'b0, 18, 0, {SB, SB, SB, SB, SB, S5});
        // next load lands in the done cycle
        run_load("dec73", 16'd73, 1'b0, 18, 5, {SB, SB, SB, SB, S7, S3});
        step();
        check_eq("dec73 single done", 42'(bus.done), 42'(0));
        run_load("min", 16'h8000, 1'b0, 18, 0, {SM, S3, S2, S7, S6, S8});
        run_load("hexFFFB", 16'hFFFB, 1'b1, 2, 0, {SB, SB, SF, SF, SF, SLB});
        run_load("hex00A0", 16'h00A0, 1'b1, 2, 0, {SB, SB, S0, S0, SA, S0});
        run_load("neg1234", 16'hFB2E, 1'b0, 18, 0, {SM, SB, S1, S2, S3, S4});
        run_load("dec10000", 16'd10000, 1'b0, 18, 0, {SB, S1, S0, S0, S0, S0});
        run_load("dec305", 16'd305, 1'b0, 18, 0, {SB, SB, SB, S3, S0, S5});
        run_load("zero", 16'd0, 1'b0, 18, 0, {SB, SB, SB, SB, SB, S0});
        step();

        // reset mid-conversion aborts the request
        bus.load = 1'b1; bus.value = 16'd5; bus.hex_mode = 1'b0;
        step();
        bus.load = 1'b0;
        for (int i = 2; i < 8; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("abort hex", hex1, RESET_HEX);
        check_eq("abort busy", 42'(bus.busy), 42'(0));
        check_eq("abort state", 42'(dbg_state), 42'(0));
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done) dcount++;
        end
        check_eq("abort no done", 42'(dcount), 42'(0));
        run_load("dec13", 16'd13, 1'b0, 18, 0, {SB, SB, SB, SB, S1, S3});

        // no leading blanking instance
        bus2.load = 1'b1; bus2.value = 16'd0; bus2.hex_mode = 1'b0;
        step();
        bus2.load = 1'b0;
        dcount = 0;
        for (int i = 2; i < 18; i++) begin
            step();
            if (bus2.done) dcount++;
        end
        check_eq("noblank early done", 42'(dcount), 42'(0));
        step();
        check_eq("noblank done", 42'(bus2.done), 42'(1));
        check_eq("noblank hex", hex2, {SB, S0, S0, S0, S0, S0});
        step();
        check_eq("noblank done pulse", 42'(bus2.done), 42'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
